// File: rtl/tx_map_pkg.sv
// Shared constants and helpers for the transmit symbol mapper: mode encoding,
// bits-per-symbol lookup and per-axis Gray-to-PAM level mapping.
package tx_map_pkg;

    localparam logic [1:0] MODE_BPSK  = 2'd0;
    localparam logic [1:0] MODE_QPSK  = 2'd1;
    localparam logic [1:0] MODE_16QAM = 2'd2;
    localparam logic [1:0] MODE_64QAM = 2'd3;

    function automatic logic [2:0] bps_of(input logic [1:0] mode);
        logic [2:0] bps;
        case (mode)
            MODE_BPSK:  bps = 3'd1;
            MODE_QPSK:  bps = 3'd2;
            MODE_16QAM: bps = 3'd4;
            default:    bps = 3'd6;
        endcase
        return bps;
    endfunction

    // axis_w = number of bits on this axis (0 = axis unused, level 0)
    function automatic logic signed [3:0] gray_pam(input logic [2:0] bits,
                                                   input logic [1:0] axis_w);
        logic signed [3:0] lvl;
        lvl = 4'sd0;
        case (axis_w)
            2'd1: lvl = bits[0] ? 4'sd1 : -4'sd1;
            2'd2: begin
                case (bits[1:0])
                    2'b00:   lvl = -4'sd3;
                    2'b01:   lvl = -4'sd1;
                    2'b11:   lvl = 4'sd1;
                    default: lvl = 4'sd3;
                endcase
            end
            2'd3: begin
                case (bits)
                    3'b000:  lvl = -4'sd7;
                    3'b001:  lvl = -4'sd5;
                    3'b011:  lvl = -4'sd3;
                    3'b010:  lvl = -4'sd1;
                    3'b110:  lvl = 4'sd1;
                    3'b111:  lvl = 4'sd3;
                    3'b101:  lvl = 4'sd5;
                    default: lvl = 4'sd7;
                endcase
            end
            default: lvl = 4'sd0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/tx_symbol_mapper_if.sv
// Bit-stream input and I/Q symbol output handshakes of the symbol mapper.
interface tx_symbol_mapper_if #(parameter int IQ_W = 8);
    logic [1:0]             mode;
    logic                   in_bit;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic signed [IQ_W-1:0] I_out;
    logic signed [IQ_W-1:0] Q_out;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   out_padded;

    modport slave (
        input  mode, in_bit, in_valid, in_last, out_ready,
        output in_ready, I_out, Q_out, out_valid, out_last, out_padded
    );

    modport master (
        output mode, in_bit, in_valid, in_last, out_ready,
        input  in_ready, I_out, Q_out, out_valid, out_last, out_padded
    );
endinterface

// File: rtl/gray_pam_axis.sv
// One axis of the constellation: Gray-coded axis bits to signed PAM level.
module gray_pam_axis
    import tx_map_pkg::*;
(
    input  logic [2:0]        axis_bits,
    input  logic [1:0]        axis_w,
    output logic signed [3:0] level
);
    assign level = gray_pam(axis_bits, axis_w);
endmodule

// File: rtl/tx_symbol_mapper.sv
// Serial bit packer + Gray I/Q mapper (BPSK/QPSK/16QAM/64QAM) with valid/ready on
// both sides and frame-end zero padding. TX_SYM_COUNT_EN adds a handoff counter.
module tx_symbol_mapper
    import tx_map_pkg::*;
#(
    parameter int IQ_W    = 8,
    parameter int AMP     = 16,
    parameter int MAX_BPS = 6
) (
    input  logic               clk,
    input  logic               reset,
    tx_symbol_mapper_if.slave  bus
`ifdef TX_SYM_COUNT_EN
    ,
    output logic [15:0]        sym_count
`endif
);
    localparam int CNT_W = $clog2(MAX_BPS);
    localparam logic signed [IQ_W-1:0] AMP_S = IQ_W'(AMP);

    if (7 * AMP > 2 ** (IQ_W - 1) - 1) begin : g_amp_chk
        $error("tx_symbol_mapper: 7*AMP exceeds signed IQ_W range");
    end
    if (MAX_BPS < 6) begin : g_bps_chk
        $error("tx_symbol_mapper: MAX_BPS must cover 64QAM (6 bits)");
    end

    logic [CNT_W-1:0]   cnt;
    logic [MAX_BPS-1:0] pack;
    logic [MAX_BPS-1:0] sym;
    logic [1:0]         mode_q;
    logic [1:0]         cur_mode;
    logic [CNT_W-1:0]   last_pos;
    logic               at_end;
    logic               would_complete;
    logic               accept;
    logic               complete;
    logic               drain;
    logic [5:0]         b6;
    logic [2:0]         i_bits, q_bits;
    logic [1:0]         i_w, q_w;
    logic signed [3:0]  i_lvl, q_lvl;
    logic signed [IQ_W-1:0] i_ext, q_ext, i_val, q_val;

    // The first bit of a symbol sees the live mode; later bits use the latched one.
    assign cur_mode       = (cnt == '0) ? bus.mode : mode_q;
    assign last_pos       = CNT_W'(bps_of(cur_mode) - 3'd1);
    assign at_end         = (cnt == last_pos);
    assign would_complete = at_end | bus.in_last;
    assign drain          = bus.out_valid & bus.out_ready;
    assign bus.in_ready   = !(would_complete & bus.out_valid & !bus.out_ready);
    assign accept         = bus.in_valid & bus.in_ready;
    assign complete       = accept & would_complete;

    // b0 sits at the MSB; unfilled positions stay zero, which is the padding.
    always_comb begin
        sym = pack;
        for (int k = 0; k < MAX_BPS; k++) begin
            if (CNT_W'(k) == cnt) sym[MAX_BPS-1-k] = bus.in_bit;
        end
    end

    assign b6 = sym[MAX_BPS-1 -: 6];

    always_comb begin
        i_bits = 3'b000;
        q_bits = 3'b000;
        i_w    = 2'd1;
        q_w    = 2'd0;
        case (cur_mode)
            MODE_BPSK: begin
                i_bits = {2'b00, b6[5]};
            end
            MODE_QPSK: begin
                i_bits = {2'b00, b6[5]};
                q_bits = {2'b00, b6[4]};
                q_w    = 2'd1;
            end
            MODE_16QAM: begin
                i_bits = {1'b0, b6[5:4]};
                q_bits = {1'b0, b6[3:2]};
                i_w    = 2'd2;
                q_w    = 2'd2;
            end
            default: begin
                i_bits = b6[5:3];
                q_bits = b6[2:0];
                i_w    = 2'd3;
                q_w    = 2'd3;
            end
        endcase
    end

    gray_pam_axis u_axis_i (.axis_bits(i_bits), .axis_w(i_w), .level(i_lvl));
    gray_pam_axis u_axis_q (.axis_bits(q_bits), .axis_w(q_w), .level(q_lvl));

    assign i_ext = {{(IQ_W-4){i_lvl[3]}}, i_lvl};
    assign q_ext = {{(IQ_W-4){q_lvl[3]}}, q_lvl};
    assign i_val = i_ext * AMP_S;
    assign q_val = q_ext * AMP_S;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            pack   <= '0;
            mode_q <= MODE_QPSK;
        end else if (accept) begin
            if (cnt == '0) mode_q <= bus.mode;
            if (would_complete) begin
                cnt  <= '0;
                pack <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
                pack <= sym;
            end
        end
    end

    // Single-entry output register; a drain and a load in one cycle gives no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.I_out      <= '0;
            bus.Q_out      <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_last   <= 1'b0;
            bus.out_padded <= 1'b0;
        end else if (complete) begin
            bus.I_out      <= i_val;
            bus.Q_out      <= q_val;
            bus.out_valid  <= 1'b1;
            bus.out_last   <= bus.in_last;
            bus.out_padded <= bus.in_last & !at_end;
        end else if (drain) begin
            bus.out_valid  <= 1'b0;
        end
    end

`ifdef TX_SYM_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_count <= '0;
        end else if (drain) begin
            sym_count <= bus.out_last ? 16'd0 : sym_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_symbol_mapper.sv
// Directed bench for tx_symbol_mapper: vector table plus stall, back-to-back,
// mode-change and reset sequences.
module tb_tx_symbol_mapper;
    import tx_map_pkg::*;

    logic clk = 1'b0;
    logic reset;
`ifdef TX_SYM_COUNT_EN
    logic [15:0] sym_count;
`endif

    always #5 clk = ~clk;

    tx_symbol_mapper_if #(.IQ_W(8)) bus ();

    tx_symbol_mapper #(.IQ_W(8), .AMP(16), .MAX_BPS(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef TX_SYM_COUNT_EN
        ,
        .sym_count (sym_count)
`endif
    );

    typedef struct {
        logic [1:0] mode;
        logic [5:0] bits;
        int         nb;
        logic       last;
        int         ei;
        int         eq;
        int         el;
        int         ep;
    } vec_t;

    vec_t vecs [12];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic [1:0] m, input logic b, input logic l);
        int n;
        n = 0;
        bus.mode     = m;
        bus.in_bit   = b;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_bit: in_ready stuck at 0 for %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic chk_out(input string name, input int ei, input int eq,
                           input int el, input int ep);
        chk({name, " valid"},  int'(bus.out_valid), 1);
        chk({name, " I"},      int'(bus.I_out), ei);
        chk({name, " Q"},      int'(bus.Q_out), eq);
        chk({name, " last"},   int'(bus.out_last), el);
        chk({name, " padded"}, int'(bus.out_padded), ep);
    endtask

    initial begin
        // b0 is bits[5]
        vecs[0]  = '{MODE_QPSK,  6'b100000, 2, 1'b0,   16,  -16, 0, 0};
        vecs[1]  = '{MODE_16QAM, 6'b100100, 4, 1'b0,   48,  -16, 0, 0};
        vecs[2]  = '{MODE_64QAM, 6'b100000, 6, 1'b0,  112, -112, 0, 0};
        vecs[3]  = '{MODE_64QAM, 6'b111000, 3, 1'b1,   48, -112, 1, 1};
        vecs[4]  = '{MODE_BPSK,  6'b000000, 1, 1'b0,  -16,    0, 0, 0};
        vecs[5]  = '{MODE_BPSK,  6'b100000, 1, 1'b0,   16,    0, 0, 0};
        vecs[6]  = '{MODE_16QAM, 6'b111000, 4, 1'b0,   16,   48, 0, 0};
        vecs[7]  = '{MODE_64QAM, 6'b011101, 6, 1'b0,  -48,   80, 0, 0};
        vecs[8]  = '{MODE_QPSK,  6'b010000, 2, 1'b1,  -16,   16, 1, 0};
        vecs[9]  = '{MODE_16QAM, 6'b000000, 1, 1'b1,  -48,  -48, 1, 1};
        vecs[10] = '{MODE_64QAM, 6'b010110, 6, 1'b0,  -16,   16, 0, 0};
        vecs[11] = '{MODE_BPSK,  6'b100000, 1, 1'b1,   16,    0, 1, 0};

        reset         = 1'b1;
        bus.mode      = MODE_QPSK;
        bus.in_bit    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid",  int'(bus.out_valid), 0);
        chk("reset I",      int'(bus.I_out), 0);
        chk("reset Q",      int'(bus.Q_out), 0);
        chk("reset last",   int'(bus.out_last), 0);
        chk("reset padded", int'(bus.out_padded), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < vecs[i].nb; k++)
                send_bit(vecs[i].mode, vecs[i].bits[5-k], vecs[i].last && (k == vecs[i].nb - 1));
            chk_out($sformatf("vec%0d", i), vecs[i].ei, vecs[i].eq, vecs[i].el, vecs[i].ep);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d drained", i), int'(bus.out_valid), 0);
        end

        // BPSK back-to-back with in_valid held high
        bus.mode     = MODE_BPSK;
        bus.in_bit   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_bit = 1'b1;
        chk_out("bpsk b2b sym0", -16, 0, 0, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk_out("bpsk b2b sym1", 16, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("bpsk b2b drained", int'(bus.out_valid), 0);

        // QPSK stall: completing bit blocked until out_ready, then loads with no loss
        bus.out_ready = 1'b0;
        send_bit(MODE_QPSK, 1'b1, 1'b0);
        send_bit(MODE_QPSK, 1'b1, 1'b0);
        chk_out("stall sym0", 16, 16, 0, 0);
        send_bit(MODE_QPSK, 1'b0, 1'b0);
        bus.mode     = MODE_QPSK;
        bus.in_bit   = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall in_ready", int'(bus.in_ready), 0);
            chk("stall hold I", int'(bus.I_out), 16);
            chk("stall hold valid", int'(bus.out_valid), 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("stall release in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk_out("stall sym1", -16, -16, 0, 0);
        @(posedge clk);
        #1;
        chk("stall drained", int'(bus.out_valid), 0);

        // Mode change after the first bit is ignored for this symbol
        send_bit(MODE_QPSK, 1'b1, 1'b0);
        send_bit(MODE_64QAM, 1'b0, 1'b0);
        chk_out("mode change", 16, -16, 0, 0);
        @(posedge clk);
        #1;

        // Reset mid-symbol: valid drops at once, partial bit discarded
        bus.out_ready = 1'b0;
        send_bit(MODE_QPSK, 1'b1, 1'b0);
        send_bit(MODE_QPSK, 1'b0, 1'b0);
        send_bit(MODE_QPSK, 1'b0, 1'b0);
        chk("pre-reset valid", int'(bus.out_valid), 1);
        reset = 1'b1;
        #1;
        chk("async reset valid", int'(bus.out_valid), 0);
        chk("async reset I", int'(bus.I_out), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        send_bit(MODE_QPSK, 1'b1, 1'b0);
        send_bit(MODE_QPSK, 1'b1, 1'b0);
        chk_out("post-reset sym", 16, 16, 0, 0);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
